// File: rtl/b_skew_feeder_if.sv
// Beat input stream for the skew feeder: valid/ready handshake plus an S-lane data bus.
interface b_skew_feeder_if #(
    parameter int N = 8,
    parameter int S = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [S*N-1:0] din;

    modport master (output in_valid, output din, input in_ready);
    modport slave  (input in_valid, input din, output in_ready);
endinterface

// File: rtl/b_skew_feeder.sv
// Systolic B-operand feeder: skews S lanes diagonally, flushes with zeros, pulses done.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; B0 holds the last job's final vector
// LOAD  | accepting K beats; each accepted beat advances every lane chain
// FLUSH | S-1 zero-injecting advances, then one quiet cycle before done
//
// The quiet cycle at the end of FLUSH lets the last b_valid cycle finish
// before done rises, so done never overlaps b_valid, and a start taken in
// the cycle after done cannot put sn on top of done.
module b_skew_feeder #(
    parameter int N  = 8,
    parameter int S  = 8,
    parameter int K  = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    b_skew_feeder_if.slave bus,
    output logic [S*N-1:0] B0,
    output logic           b_valid,
    output logic           sn,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CW-1:0] K_LAST    = CW'(K - 1);
    localparam logic [CW-1:0] FLUSH_LEN = CW'(S - 1);

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] flush_cnt;
    logic          advance;
    logic          clr;

    assign advance      = ((state == LOAD) && bus.in_valid) ||
                          ((state == FLUSH) && (flush_cnt != '0));
    assign clr          = (state == IDLE) && start;
    assign bus.in_ready = (state == LOAD);
    assign busy         = (state != IDLE);

    // Sequencer: beat counting, flush down-counter and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            sn        <= 1'b0;
            done      <= 1'b0;
            b_valid   <= 1'b0;
        end else begin
            sn      <= 1'b0;
            done    <= 1'b0;
            b_valid <= advance;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        sn        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == K_LAST) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_LEN;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt != '0) begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < S; j++) begin : g_lane
        logic [N-1:0] chain [0:j];
        logic [N-1:0] head;

        assign head = (state == LOAD) ? bus.din[(S-j)*N-1 -: N] : '0;

        // Lane j delay line: j+1 stages, shifted only on an advance.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= j; k++) chain[k] <= '0;
            end else if (clr) begin
                for (int k = 0; k <= j; k++) chain[k] <= '0;
            end else if (advance) begin
                chain[0] <= head;
                for (int k = 1; k <= j; k++) chain[k] <= chain[k-1];
            end
        end

        assign B0[(S-j)*N-1 -: N] = chain[j];
    end

endmodule

// File: tb/tb_b_skew_feeder.sv
// Bench for b_skew_feeder: directed and random jobs against a lane/step reference model.
module tb_b_skew_feeder;
    localparam int N = 8;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic [S*N-1:0] din;
    logic           sel;

    logic           start_a, start_b;
    logic [S*N-1:0] b0_a, b0_b;
    logic           bv_a, bv_b, sn_a, sn_b, busy_a, busy_b, done_a, done_b;

    logic [S*N-1:0] b0_o;
    logic           bv_o, sn_o, busy_o, done_o, ready_o;

    int             tests = 0;
    int             fails = 0;
    logic [N-1:0]   beat_mem [8][S];
    logic [S*N-1:0] last_b0;

    b_skew_feeder_if #(.N(N), .S(S)) ifa ();
    b_skew_feeder_if #(.N(N), .S(S)) ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.din      = din;
    assign ifb.in_valid = in_valid;
    assign ifb.din      = din;
    assign start_a      = start && !sel;
    assign start_b      = start && sel;

    b_skew_feeder #(.N(N), .S(S), .K(3), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
        .B0(b0_a), .b_valid(bv_a), .sn(sn_a), .busy(busy_a), .done(done_a)
    );

    b_skew_feeder #(.N(N), .S(S), .K(1), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
        .B0(b0_b), .b_valid(bv_b), .sn(sn_b), .busy(busy_b), .done(done_b)
    );

    assign b0_o    = sel ? b0_b : b0_a;
    assign bv_o    = sel ? bv_b : bv_a;
    assign sn_o    = sel ? sn_b : sn_a;
    assign busy_o  = sel ? busy_b : busy_a;
    assign done_o  = sel ? done_b : done_a;
    assign ready_o = sel ? ifb.in_ready : ifa.in_ready;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [S*N-1:0] got, input logic [S*N-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [S*N-1:0] pack(input int b);
        logic [S*N-1:0] r;
        r = '0;
        for (int j = 0; j < S; j++) r[(S-j)*N-1 -: N] = beat_mem[b][j];
        return r;
    endfunction

    // Step t (1-based): lane j carries beat t-1-j if that beat exists, else zero.
    function automatic logic [S*N-1:0] exp_b0(input int step, input int kk);
        logic [S*N-1:0] r;
        int b;
        r = '0;
        for (int j = 0; j < S; j++) begin
            b = step - 1 - j;
            if (b >= 0 && b < kk) r[(S-j)*N-1 -: N] = beat_mem[b][j];
        end
        return r;
    endfunction

    // Caller is at a negedge; start is driven now and sampled on the next posedge.
    task automatic run_job(input bit use_b, input int kk, input int stall_at,
                           input int stall_len, input bit poke, input int abort_at);
        int beats_sent = 0;
        int stalled    = 0;
        int step       = 0;
        int flush_left = 0;
        int exp_done;
        bit exp_bv     = 1'b0;
        exp_done = kk + stall_len + S + 1;
        sel      = use_b;
        start    = 1'b1;
        in_valid = 1'b0;
        last_b0  = '0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= exp_done; n++) begin
            chk1("sn", sn_o, n == 1);
            chk1("busy", busy_o, n < exp_done);
            chk1("in_ready", ready_o, beats_sent < kk);
            chk1("done", done_o, n == exp_done);
            chk1("b_valid", bv_o, exp_bv);
            if (exp_bv) begin
                step++;
                last_b0 = exp_b0(step, kk);
            end
            chkv("B0", b0_o, last_b0);
            if (n == abort_at) begin
                rst = 1'b0;
                in_valid = 1'b0;
                #1;
                chkv("abort_B0", b0_o, '0);
                chk1("abort_busy", busy_o, 1'b0);
                chk1("abort_in_ready", ready_o, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    chk1("abort_no_done", done_o, 1'b0);
                end
                rst = 1'b1;
                last_b0 = '0;
                return;
            end
            if (n == exp_done) break;
            start = poke && (n == 2);
            if (beats_sent < kk) begin
                if (beats_sent == stall_at && stalled < stall_len) begin
                    in_valid = 1'b0;
                    din      = $urandom;
                    stalled++;
                    exp_bv   = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    din      = pack(beats_sent);
                    beats_sent++;
                    exp_bv   = 1'b1;
                    if (beats_sent == kk) flush_left = S - 1;
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                din      = $urandom;
                if (flush_left > 0) begin
                    flush_left--;
                    exp_bv = 1'b1;
                end else begin
                    exp_bv = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // One IDLE cycle with junk on the input bus; nothing may move.
    task automatic idle_poke();
        in_valid = 1'b1;
        din      = '1;
        start    = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy_o, 1'b0);
        chk1("idle_in_ready", ready_o, 1'b0);
        chk1("idle_b_valid", bv_o, 1'b0);
        chk1("idle_done", done_o, 1'b0);
        chkv("idle_B0_hold", b0_o, last_b0);
        in_valid = 1'b0;
    endtask

    task automatic load_basic();
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < S; j++) beat_mem[b][j] = 8'(16 * b + j + 1);
    endtask

    task automatic load_random();
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < S; j++) beat_mem[b][j] = 8'($urandom_range(1, 255));
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        sel      = 1'b0;
        last_b0  = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chkv("rst_B0", b0_o, '0);
            chk1("rst_b_valid", bv_o, 1'b0);
            chk1("rst_sn", sn_o, 1'b0);
            chk1("rst_busy", busy_o, 1'b0);
            chk1("rst_done", done_o, 1'b0);
            chk1("rst_in_ready", ready_o, 1'b0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // basic skew
        load_basic();
        run_job(1'b0, 3, 99, 0, 1'b0, 0);
        idle_poke();

        // two-cycle stall after the first beat
        run_job(1'b0, 3, 1, 2, 1'b0, 0);
        idle_poke();

        // reset during the second flush cycle, then a fresh basic job
        run_job(1'b0, 3, 99, 0, 1'b0, 5);
        idle_poke();
        run_job(1'b0, 3, 99, 0, 1'b0, 0);

        // junk in IDLE plus a start pulse during LOAD
        idle_poke();
        run_job(1'b0, 3, 99, 0, 1'b1, 0);

        // single-beat job on the K=1 instance
        for (int j = 0; j < S; j++) beat_mem[0][j] = 8'(10 + j);
        sel     = 1'b1;
        last_b0 = '0;
        idle_poke();
        run_job(1'b1, 1, 99, 0, 1'b0, 0);
        idle_poke();

        // back-to-back: start in the cycle right after done
        load_basic();
        @(negedge clk);
        run_job(1'b0, 3, 99, 0, 1'b0, 0);
        load_random();
        @(negedge clk);
        chk1("b2b_done_low", done_o, 1'b0);
        chk1("b2b_busy_low", busy_o, 1'b0);
        run_job(1'b0, 3, 99, 0, 1'b0, 0);

        // random jobs with random stalls, alternating instances
        for (int r = 0; r < 8; r++) begin
            load_random();
            @(negedge clk);
            if (r % 3 == 2)
                run_job(1'b1, 1, 0, $urandom_range(0, 3), 1'b0, 0);
            else
                run_job(1'b0, 3, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
